// File: rtl/prog_mem_ctrl_if.sv
// Host-loader, instruction-fetch and program-memory signal bundle for prog_mem_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface prog_mem_ctrl_if;
  localparam int unsigned AW = 16;
  localparam int unsigned HW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 14;

  logic          load_mode;
  logic          host_start;
  logic [AW-1:0] host_base;
  logic          host_wvalid;
  logic          host_wready;
  logic [HW-1:0] host_wdata;
  logic          load_done;
  logic [CW-1:0] load_count;
  logic          err_oob;
  logic          err_partial;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic          fetch_err;
  logic          prog_en_h;
  logic          w_en;
  logic [AW-1:0] adr_p_mem;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  modport slave (
    input  load_mode, host_start, host_base, host_wvalid, host_wdata,
           fetch_req, fetch_addr, data_out,
    output host_wready, load_done, load_count, err_oob, err_partial,
           fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           prog_en_h, w_en, adr_p_mem, data_in
  );

  modport master (
    output load_mode, host_start, host_base, host_wvalid, host_wdata,
           fetch_req, fetch_addr, data_out,
    input  host_wready, load_done, load_count, err_oob, err_partial,
           fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           prog_en_h, w_en, adr_p_mem, data_in
  );
endinterface

// File: rtl/prog_mem_ctrl.sv
// Arbitrates the 64-bit program memory between a half-word host loader and a
// pipelined instruction-fetch port, suppressing writes beyond WORDS.
module prog_mem_ctrl #(
  parameter int unsigned WORDS = 8192
) (
  input  logic            clk,
  input  logic            rst_n,
  prog_mem_ctrl_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned HW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 14;
  localparam logic [AW:0] LIMIT = (AW+1)'(WORDS);

  typedef enum logic [2:0] {IDLE, READ, LOAD_LO, LOAD_HI, WRITE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] wptr, wptr_d;
  logic [HW-1:0] lo_half, lo_half_d;

  logic          prog_en_h_d, w_en_d, wready_d, done_d;
  logic [AW-1:0] adr_d;
  logic [DW-1:0] data_in_d;
  logic [CW-1:0] count_d;
  logic          oob_d, partial_d, rvalid_d, ferr_d;

  logic gnt, wr_hs, fetch_in_range, wptr_in_range;

  assign fetch_in_range = {1'b0, bus.fetch_addr} < LIMIT;
  assign wptr_in_range  = {1'b0, wptr} < LIMIT;
  assign gnt   = bus.fetch_req & ~bus.load_mode & rst_n & ((state == IDLE) | (state == READ));
  assign wr_hs = bus.host_wvalid & bus.host_wready;

  assign bus.fetch_gnt   = gnt;
  assign bus.fetch_rdata = (bus.fetch_rvalid && !bus.fetch_err) ? bus.data_out : '0;

  // Next-state and next-output decode
  always_comb begin
    state_d     = state;
    wptr_d      = wptr;
    lo_half_d   = lo_half;
    prog_en_h_d = 1'b0;
    w_en_d      = 1'b0;
    adr_d       = bus.adr_p_mem;
    data_in_d   = bus.data_in;
    wready_d    = 1'b0;
    done_d      = 1'b0;
    count_d     = bus.load_count;
    oob_d       = bus.err_oob;
    partial_d   = bus.err_partial;
    // In READ, prog_en_h low means the issued address was out of range
    rvalid_d    = (state == READ);
    ferr_d      = (state == READ) & ~bus.prog_en_h;

    unique case (state)
      IDLE, READ: begin
        if (gnt) begin
          state_d     = READ;
          prog_en_h_d = fetch_in_range;
          adr_d       = bus.fetch_addr;
        end else if (state == IDLE && bus.load_mode && bus.host_start) begin
          state_d   = LOAD_LO;
          wptr_d    = bus.host_base;
          count_d   = '0;
          oob_d     = 1'b0;
          partial_d = 1'b0;
          wready_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_LO: begin
        if (!bus.load_mode) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.host_start) begin
          wptr_d    = bus.host_base;
          count_d   = '0;
          oob_d     = 1'b0;
          partial_d = 1'b0;
          wready_d  = 1'b1;
        end else if (wr_hs) begin
          lo_half_d = bus.host_wdata;
          state_d   = LOAD_HI;
          wready_d  = 1'b1;
        end else begin
          wready_d = 1'b1;
        end
      end
      LOAD_HI: begin
        if (!bus.load_mode) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          partial_d = 1'b1;
        end else if (wr_hs) begin
          state_d = WRITE;
          if (wptr_in_range) begin
            prog_en_h_d = 1'b1;
            w_en_d      = 1'b1;
            adr_d       = wptr;
            data_in_d   = {bus.host_wdata, lo_half};
          end
        end else begin
          wready_d = 1'b1;
        end
      end
      WRITE: begin
        // A load_mode fall here is handled by the following LOAD_LO cycle
        state_d  = LOAD_LO;
        wready_d = 1'b1;
        wptr_d   = wptr + AW'(1);
        if (wptr_in_range) count_d = bus.load_count + CW'(1);
        else               oob_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wptr             <= '0;
      lo_half          <= '0;
      bus.prog_en_h    <= 1'b0;
      bus.w_en         <= 1'b0;
      bus.adr_p_mem    <= '0;
      bus.data_in      <= '0;
      bus.host_wready  <= 1'b0;
      bus.load_done    <= 1'b0;
      bus.load_count   <= '0;
      bus.err_oob      <= 1'b0;
      bus.err_partial  <= 1'b0;
      bus.fetch_rvalid <= 1'b0;
      bus.fetch_err    <= 1'b0;
    end else begin
      state            <= state_d;
      wptr             <= wptr_d;
      lo_half          <= lo_half_d;
      bus.prog_en_h    <= prog_en_h_d;
      bus.w_en         <= w_en_d;
      bus.adr_p_mem    <= adr_d;
      bus.data_in      <= data_in_d;
      bus.host_wready  <= wready_d;
      bus.load_done    <= done_d;
      bus.load_count   <= count_d;
      bus.err_oob      <= oob_d;
      bus.err_partial  <= partial_d;
      bus.fetch_rvalid <= rvalid_d;
      bus.fetch_err    <= ferr_d;
    end
  end
endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Bench for prog_mem_ctrl: cycle table for a load, scoreboard for fetch
// responses, and hand sequences for boundary, partial, arbitration and reset.
module tb_prog_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_mem_ctrl_if bus();
  prog_mem_ctrl #(.WORDS(8192)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Behavioural memory: write on enable, read data valid the following cycle
  logic [63:0] mem [8192];
  int          n_wr = 0;
  logic [15:0] last_wa = '0;
  logic [63:0] last_wd = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.prog_en_h && bus.w_en) begin
      mem[bus.adr_p_mem[12:0]] <= bus.data_in;
      n_wr    <= n_wr + 1;
      last_wa <= bus.adr_p_mem;
      last_wd <= bus.data_in;
    end
    if (bus.prog_en_h && !bus.w_en) bus.data_out <= mem[bus.adr_p_mem[12:0]];
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t        sb[$];
  logic [63:0] exp_mem [int];

  // Scoreboard: retire responses first, then record new grants
  always @(negedge clk) begin
    rsp_t r;
    if (bus.fetch_rvalid) begin
      n_rsp <= n_rsp + 1;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 128'(bus.fetch_rvalid), 128'(0));
      end else begin
        r = sb.pop_front();
        check("rsp_data", 128'({bus.fetch_err, bus.fetch_rdata}), 128'({r.err, r.data}));
        check("rsp_latency", 128'(cyc), 128'(r.cyc + 2));
      end
    end
    if (bus.fetch_gnt) begin
      r.cyc = cyc;
      if (bus.fetch_addr >= 16'd8192) begin
        r.err  = 1'b1;
        r.data = '0;
      end else begin
        r.err  = 1'b0;
        r.data = exp_mem.exists(int'(bus.fetch_addr)) ? exp_mem[int'(bus.fetch_addr)] : 'x;
      end
      sb.push_back(r);
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({bus.prog_en_h, bus.w_en, bus.adr_p_mem, bus.data_in, bus.host_wready,
                 bus.load_done, bus.load_count, bus.err_oob, bus.err_partial,
                 bus.fetch_rvalid, bus.fetch_err, bus.fetch_gnt});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_half(input logic [31:0] d);
    bus.host_wvalid = 1'b1;
    bus.host_wdata  = d;
    for (int i = 0; i < 20; i++) begin
      if (bus.host_wready) begin
        step();
        bus.host_wvalid = 1'b0;
        return;
      end
      step();
    end
    bus.host_wvalid = 1'b0;
    check("wready_timeout", 128'(bus.host_wready), 128'(1));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20; i++) begin
      if (bus.load_done) break;
      step();
    end
    check(name, 128'(bus.load_done), 128'(1));
  endtask

  task automatic drain(input string name, input int rsp0, input int want);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    step();
    check({name, "_queue"}, 128'(sb.size()), 128'(0));
    check({name, "_count"}, 128'(n_rsp - rsp0), 128'(want));
  endtask

  task automatic start_load(input logic [15:0] base);
    bus.load_mode  = 1'b1;
    bus.host_start = 1'b1;
    bus.host_base  = base;
    step();
    bus.host_start = 1'b0;
  endtask

  typedef struct {
    logic        lm, st;
    logic [15:0] base;
    logic        wv;
    logic [31:0] wd;
    logic        wready, pe, we;
    logic [15:0] adr;
    logic [63:0] din;
    logic [13:0] cnt;
    logic        done;
  } vec_t;
  vec_t tv[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, r0;
    localparam logic [63:0] W0 = 64'h2222222211111111;
    localparam logic [63:0] W1 = 64'h4444444433333333;

    tv[0] = '{1'b1, 1'b1, 16'h0010, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0000, 64'h0, 14'd0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 16'h0000, 64'h0, 14'd0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b1, 16'h0010, W0,    14'd0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 16'h0010, W0,    14'd1, 1'b0};
    tv[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0, 16'h0010, W0,    14'd1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b1, 16'h0011, W1,    14'd1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0011, W1,    14'd2, 1'b0};
    tv[7] = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 16'h0011, W1,    14'd2, 1'b0};
    tv[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'h0011, W1,    14'd2, 1'b1};
    tv[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 16'h0011, W1,    14'd2, 1'b0};

    bus.load_mode   = 1'b0;
    bus.host_start  = 1'b0;
    bus.host_base   = '0;
    bus.host_wvalid = 1'b0;
    bus.host_wdata  = '0;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = 16'h0010;
    bus.data_out    = '0;

    #12;
    check("reset_outputs", all_outs(), 128'(0));
    bus.fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load two words at 0x0010, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      bus.load_mode   = tv[i].lm;
      bus.host_start  = tv[i].st;
      bus.host_base   = tv[i].base;
      bus.host_wvalid = tv[i].wv;
      bus.host_wdata  = tv[i].wd;
      step();
      check($sformatf("vec%0d", i),
            128'({bus.host_wready, bus.prog_en_h, bus.w_en, bus.adr_p_mem, bus.data_in, bus.load_count, bus.load_done}),
            128'({tv[i].wready, tv[i].pe, tv[i].we, tv[i].adr, tv[i].din, tv[i].cnt, tv[i].done}));
    end
    exp_mem[16'h0010] = W0;
    exp_mem[16'h0011] = W1;

    // Pipelined fetch of the two words
    r0 = n_rsp;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0010;
    #1 check("gnt_t0", 128'(bus.fetch_gnt), 128'(1));
    step();
    check("issue_t0", 128'({bus.prog_en_h, bus.w_en, bus.adr_p_mem}), 128'({1'b1, 1'b0, 16'h0010}));
    bus.fetch_addr = 16'h0011;
    #1 check("gnt_t1", 128'(bus.fetch_gnt), 128'(1));
    step();
    check("issue_t1", 128'({bus.prog_en_h, bus.w_en, bus.adr_p_mem}), 128'({1'b1, 1'b0, 16'h0011}));
    bus.fetch_req = 1'b0;
    drain("fetch_pair", r0, 2);

    // Boundary: second word lands at 0x2000 and is suppressed
    n0 = n_wr;
    start_load(16'h1FFF);
    host_half(32'hAAAA0001);
    host_half(32'hBBBB0001);
    host_half(32'hAAAA0002);
    host_half(32'hBBBB0002);
    step();
    check("oob_flags", 128'({bus.load_count, bus.err_oob, bus.err_partial}), 128'({14'd1, 1'b1, 1'b0}));
    check("oob_writes", 128'(n_wr - n0), 128'(1));
    check("oob_last_write", 128'({last_wa, last_wd}), 128'({16'h1FFF, 64'hBBBB0001AAAA0001}));
    exp_mem[16'h1FFF] = 64'hBBBB0001AAAA0001;
    bus.load_mode = 1'b0;
    wait_done("done_oob");

    r0 = n_rsp;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h1FFF;
    #1 check("gnt_last", 128'(bus.fetch_gnt), 128'(1));
    step();
    bus.fetch_addr = 16'h2000;
    #1 check("gnt_oob", 128'(bus.fetch_gnt), 128'(1));
    step();
    check("oob_issue", 128'({bus.prog_en_h, bus.adr_p_mem}), 128'({1'b0, 16'h2000}));
    bus.fetch_req = 1'b0;
    drain("fetch_oob", r0, 2);

    // Partial word: low half only, then load_mode falls
    n0 = n_wr;
    start_load(16'h0100);
    host_half(32'hCAFE0000);
    bus.load_mode = 1'b0;
    wait_done("done_partial");
    check("partial_flags", 128'({bus.load_count, bus.err_oob, bus.err_partial}), 128'({14'd0, 1'b0, 1'b1}));
    check("partial_writes", 128'(n_wr - n0), 128'(0));

    // Arbitration: load_mode rises with two reads in flight
    r0 = n_rsp;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0010;
    #1 check("arb_gnt0", 128'(bus.fetch_gnt), 128'(1));
    step();
    bus.fetch_addr = 16'h0011;
    #1 check("arb_gnt1", 128'(bus.fetch_gnt), 128'(1));
    step();
    bus.load_mode  = 1'b1;
    bus.host_start = 1'b1;
    bus.host_base  = 16'h0200;
    #1 check("arb_gnt_blocked_read", 128'(bus.fetch_gnt), 128'(0));
    step();
    check("arb_start_ignored", 128'(bus.host_wready), 128'(0));
    #1 check("arb_gnt_blocked_idle", 128'(bus.fetch_gnt), 128'(0));
    step();
    check("arb_start_in_idle", 128'(bus.host_wready), 128'(1));
    bus.host_start = 1'b0;
    bus.fetch_req  = 1'b0;
    drain("arb", r0, 2);
    bus.load_mode = 1'b0;
    wait_done("done_arb");

    // Asynchronous reset in the middle of a WRITE cycle
    start_load(16'h0300);
    host_half(32'h55555555);
    host_half(32'h66666666);
    check("write_armed", 128'({bus.prog_en_h, bus.w_en}), 128'({1'b1, 1'b1}));
    n0 = n_wr;
    bus.fetch_req = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_write", all_outs(), 128'(0));
    step();
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.load_mode = 1'b0;
    rst_n = 1'b1;
    step();
    check("reset_no_write", 128'(n_wr - n0), 128'(0));

    r0 = n_rsp;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 16'h0011;
    #1 check("gnt_after_reset", 128'(bus.fetch_gnt), 128'(1));
    step();
    bus.fetch_req = 1'b0;
    drain("fetch_after_reset", r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
